// File: rtl/uart_rx_framed_if.sv
// Receive-side valid/ready stream carrying one decoded UART word plus its error flags.
// The receiver drives through the master modport; the consumer uses the slave modport.
interface uart_rx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_BITS-1:0] m_data;
    logic                 m_ferr;
    logic                 m_perr;

    modport master (output m_valid, output m_data, output m_ferr, output m_perr, input m_ready);
    modport slave  (input m_valid, input m_data, input m_ferr, input m_perr, output m_ready);
endinterface

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver with 2-of-3 bit voting, framing/parity flags and a word FIFO.
// Optional parity bit after the data is enabled by defining UART_RX_PARITY_EN.
module uart_rx_framed #(
    parameter int DATA_BITS    = 8,
    parameter int OVERSAMPLING = 16,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clock_out,
    input  logic                          nreset,
    input  logic                          sdata,
    input  logic                          rx_en,
    input  logic                          clr_status,
    uart_rx_framed_if.master              m_if,
    output logic                          overrun,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int TW = $clog2(OVERSAMPLING);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int EW = DATA_BITS + 2;
    localparam logic [TW-1:0] TAP_LO    = TW'(OVERSAMPLING / 2 - 1);
    localparam logic [TW-1:0] TAP_MID   = TW'(OVERSAMPLING / 2);
    localparam logic [TW-1:0] TAP_VOTE  = TW'(OVERSAMPLING / 2 + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   LVL_ONE   = (PW + 1)'(1);
    localparam logic [PW:0]   LVL_FULL  = (PW + 1)'(FIFO_DEPTH);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLING < 8 || (OVERSAMPLING % 2) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_rx_framed: illegal parameter combination");
    end

`ifdef UART_RX_PARITY_EN
    function automatic logic parity_f(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, sync3_q;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [1:0]           tap_q, tap_d;
    logic                 ferr_q, ferr_d, perr_q, perr_d;
    logic                 armed_q, armed_d;
    logic                 busy_q, overrun_q, overrun_d;
    logic                 vote_s, vote_now_s, wrap_s, push_s, ferr_now_s;
    logic                 full_s, pop_s, wr_s, ovf_s;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        head_s;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PW:0]          level_q;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= sdata;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign vote_s     = (tap_q[0] & tap_q[1]) | (tap_q[0] & sync2_q) | (tap_q[1] & sync2_q);
    assign vote_now_s = (tick_q == TAP_VOTE);
    assign wrap_s     = (tick_q == TICK_LAST);

    // Capture the two early voting taps; the third tap is the live sample at the vote tick.
    always_comb begin
        tap_d = tap_q;
        if (tick_q == TAP_LO) begin
            tap_d[0] = sync2_q;
        end else if (tick_q == TAP_MID) begin
            tap_d[1] = sync2_q;
        end else begin
            tap_d = tap_q;
        end
    end

    // Frame FSM: next state, counters, shift register and per-word error flags.
    always_comb begin
        state_d    = state_q;
        tick_d     = wrap_s ? '0 : tick_q + TICK_ONE;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        ferr_d     = ferr_q;
        perr_d     = perr_q;
        armed_d    = armed_q;
        push_s     = 1'b0;
        ferr_now_s = ferr_q;
        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (sync3_q && !sync2_q && rx_en && armed_q) begin
                    state_d = S_START;
                    armed_d = 1'b0;
                    bit_d   = '0;
                    ferr_d  = 1'b0;
                    perr_d  = 1'b0;
                end else if (sync2_q) begin
                    armed_d = 1'b1;
                end else begin
                    armed_d = armed_q;
                end
            end
            S_START: begin
                if (vote_now_s && vote_s) begin
                    state_d = S_IDLE;
                end else if (wrap_s) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (vote_now_s) begin
                    shreg_d = {vote_s, shreg_q[DATA_BITS-1:1]};
                end else begin
                    shreg_d = shreg_q;
                end
                if (wrap_s && bit_q == LAST_DATA) begin
                    bit_d = '0;
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end else if (wrap_s) begin
                    bit_d = bit_q + BIT_ONE;
                end else begin
                    bit_d = bit_q;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (vote_now_s) begin
                    perr_d = vote_s ^ parity_f(shreg_q) ^ (PARITY_ODD != 0);
                end else begin
                    perr_d = perr_q;
                end
                if (wrap_s) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                // The last stop vote pushes and returns to IDLE at once so an early start is caught.
                if (vote_now_s) begin
                    ferr_now_s = ferr_q | ~vote_s;
                    ferr_d     = ferr_now_s;
                    if (bit_q == LAST_STOP) begin
                        push_s  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STOP;
                    end
                end else if (wrap_s) begin
                    bit_d = bit_q + BIT_ONE;
                end else begin
                    bit_d = bit_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame FSM and receive datapath registers.
    always_ff @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tap_q   <= 2'b11;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            armed_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tap_q   <= tap_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            armed_q <= armed_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign full_s    = (level_q == LVL_FULL);
    assign pop_s     = (level_q != '0) && m_if.m_ready;
    assign wr_s      = push_s && (!full_s || pop_s);
    assign ovf_s     = push_s && full_s && !pop_s;
    assign overrun_d = ovf_s ? 1'b1 : (clr_status ? 1'b0 : overrun_q);

    // Word FIFO; a simultaneous pop frees the slot the push needs when full.
    always_ff @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_q[wr_ptr_q] <= {perr_q, ferr_now_s, shreg_q};
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({wr_s, pop_s})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
            overrun_q <= overrun_d;
        end
    end

    assign head_s       = mem_q[rd_ptr_q];
    assign m_if.m_valid = (level_q != '0);
    assign m_if.m_data  = head_s[DATA_BITS-1:0];
    assign m_if.m_ferr  = head_s[DATA_BITS];
    assign m_if.m_perr  = head_s[DATA_BITS+1];
    assign overrun      = overrun_q;
    assign busy         = busy_q;
    assign fifo_level   = level_q;
endmodule

// File: tb/tb_uart_rx_framed.sv
// Self-checking bench for uart_rx_framed: frame table, glitch, break, overrun and reset sequences.
// Expected words go into a scoreboard queue as frames are driven and are compared on every pop.
module tb_uart_rx_framed;
    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif
    localparam bit PODD = 1'b0;
    localparam int FRAME_BITS = 1 + 8 + (PAR_ON ? 1 : 0) + 1;

    logic       clock_out = 1'b0;
    logic       nreset = 1'b0;
    logic       sdata = 1'b1;
    logic       rx_en = 1'b1;
    logic       clr_status = 1'b0;
    logic       overrun, busy;
    logic [2:0] fifo_level;

    uart_rx_framed_if #(.DATA_BITS(8)) m_if ();

    uart_rx_framed #(
        .DATA_BITS(8), .OVERSAMPLING(OS), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) dut (
        .clock_out(clock_out), .nreset(nreset), .sdata(sdata), .rx_en(rx_en),
        .clr_status(clr_status), .m_if(m_if), .overrun(overrun), .busy(busy),
        .fifo_level(fifo_level)
    );

    always #5 clock_out = ~clock_out;

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       stop0;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    int         pass_cnt = 0;
    int         chk_cnt = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every handshake must match the oldest expected word.
    always begin
        @(negedge clock_out);
        #4;
        if (nreset && m_if.m_valid && m_if.m_ready) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL pop_unexpected: got word 0x%0h with no word expected at %0t",
                         {m_if.m_perr, m_if.m_ferr, m_if.m_data}, $time);
            end else begin
                check("pop_word", {22'd0, m_if.m_perr, m_if.m_ferr, m_if.m_data}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic drive_bit(input logic v);
        sdata = v;
        repeat (OS) @(negedge clock_out);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop0,
                              input logic pop_at_push, output logic mid_busy);
        mid_busy = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) mid_busy = busy;
            drive_bit(d[i]);
        end
        if (PAR_ON) drive_bit((^d) ^ PODD ^ bad_par);
        sdata = ~stop0;
        for (int i = 0; i < OS; i++) begin
            if (pop_at_push && i == 12) m_if.m_ready = 1'b1;
            if (pop_at_push && i == 13) m_if.m_ready = 1'b0;
            @(negedge clock_out);
        end
        sdata = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clock_out);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        vec_t       vec[6];
        logic       mb;
        m_if.m_ready = 1'b1;
        vec[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        vec[1] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, PAR_ON};
        vec[2] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0};
        vec[3] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vec[4] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vec[5] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, PAR_ON};

        repeat (3) @(negedge clock_out);
        check("rst_valid", m_if.m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overrun", overrun, 0);
        check("rst_data", {m_if.m_perr, m_if.m_ferr, m_if.m_data}, 0);
        nreset = 1'b1;
        repeat (OS) @(negedge clock_out);

        // Table-driven frames with the consumer always ready.
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back({vec[v].exp_perr, vec[v].exp_ferr, vec[v].exp_data});
            send_frame(vec[v].data, vec[v].bad_par, vec[v].stop0, 1'b0, mb);
            check("busy_mid", mb, 1);
            check("busy_end", busy, 0);
            wait_drain("frame_drain");
            drive_bit(1'b1);
        end

        // Short low glitch on an idle line must be rejected.
        sdata = 1'b0;
        repeat (3) @(negedge clock_out);
        sdata = 1'b1;
        repeat (OS / 2 + 2) @(negedge clock_out);
        check("glitch_busy", busy, 0);
        repeat (OS) @(negedge clock_out);
        check("glitch_level", fifo_level, 0);

        // Break: a held-low line yields exactly one zero word with a framing error.
        exp_q.push_back({1'b0, 1'b1, 8'h00});
        sdata = 1'b0;
        repeat (3 * FRAME_BITS * OS) @(negedge clock_out);
        check("break_words", exp_q.size(), 0);
        check("break_busy", busy, 0);
        check("break_level", fifo_level, 0);
        drive_bit(1'b1);
        drive_bit(1'b1);

        // New starts blocked while rx_en is low.
        rx_en = 1'b0;
        send_frame(8'h77, 1'b0, 1'b0, 1'b0, mb);
        check("rxen_busy", mb, 0);
        check("rxen_level", fifo_level, 0);
        rx_en = 1'b1;
        drive_bit(1'b1);

        // Overrun: five frames into a four-deep FIFO with no consumer.
        m_if.m_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_q.push_back({2'b00, 8'(k)});
            send_frame(8'(k), 1'b0, 1'b0, 1'b0, mb);
            drive_bit(1'b1);
        end
        check("ovf_level", fifo_level, 4);
        check("ovf_flag", overrun, 1);
        check("ovf_head", m_if.m_data, 8'h01);
        m_if.m_ready = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_sticky", overrun, 1);
        clr_status = 1'b1;
        @(negedge clock_out);
        clr_status = 1'b0;
        @(negedge clock_out);
        check("ovf_clear", overrun, 0);

        // Full FIFO with a pop in the very cycle of the push: no overrun.
        m_if.m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({2'b00, 8'(8'h11 + k)});
            send_frame(8'(8'h11 + k), 1'b0, 1'b0, k == 4, mb);
            drive_bit(1'b1);
        end
        check("pp_level", fifo_level, 4);
        check("pp_overrun", overrun, 0);
        check("pp_head", m_if.m_data, 8'h12);
        m_if.m_ready = 1'b1;
        wait_drain("pp_drain");

        // Reset in the middle of a frame discards it.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        sdata = 1'b1;
        nreset = 1'b0;
        repeat (3) @(negedge clock_out);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", m_if.m_valid, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_data", {m_if.m_perr, m_if.m_ferr, m_if.m_data}, 0);
        nreset = 1'b1;
        drive_bit(1'b1);
        exp_q.push_back({2'b00, 8'h66});
        send_frame(8'h66, 1'b0, 1'b0, 1'b0, mb);
        wait_drain("post_rst_drain");
        drive_bit(1'b1);
        check("final_level", fifo_level, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
